// File: rtl/bg_line_fetcher.sv
// bg_line_fetcher
// Background-layer fetcher for the VDP render path. On each line start it walks one
// name-table row, reads the per-tile pattern planes from VRAM and writes decoded
// {priority, palette, colour} pixels into the fetch half of a double-buffered line
// buffer, while the pixel mixer reads the other (display) half.
//
// Ports
//   clk_i, rst_i              clock, async active-high reset
//   line_start_i              1-cycle pulse: swap banks, start fetching the new line
//   row_i, h_scroll_i, v_scroll_i, h_scroll_inhib_i, v_scroll_inhib_i,
//   name_base_i, pattern_base_i   line parameters, latched on line_start_i
//   vram_addr_o / vram_data_i VRAM read port, data one cycle after address
//   rd_addr_i / rd_data_o     mixer read of the display bank, one cycle latency
//   busy_o, done_o, overrun_o fetch status; done/overrun are 1-cycle pulses
//
// state     | meaning
// IDLE      | waiting for line start
// NAME_LO   | present name word low byte address
// NAME_HI   | present high byte address, capture low byte
// DECODE    | capture high byte (tile, flips, palette, priority)
// PLANE     | present plane k address, capture plane k-1
// LAST      | capture the final plane
// EMIT      | write 8 pixels, one per cycle
// DONE      | mark fetch bank valid, pulse done
module bg_line_fetcher #(
  parameter int NUM_COLS    = 32,
  parameter int BPP         = 4,
  parameter int ADDR_W      = 14,
  parameter int VIS_ROWS    = 224,
  parameter int HINHIB_ROWS = 16,
  parameter int VLOCK_COL   = 24,
  localparam int LINE_PIX   = 8 * NUM_COLS,
  localparam int XW         = $clog2(LINE_PIX)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              line_start_i,
  input  logic [7:0]        row_i,
  input  logic [XW-1:0]     h_scroll_i,
  input  logic [7:0]        v_scroll_i,
  input  logic              h_scroll_inhib_i,
  input  logic              v_scroll_inhib_i,
  input  logic [ADDR_W-1:0] name_base_i,
  input  logic [ADDR_W-1:0] pattern_base_i,
  output logic [ADDR_W-1:0] vram_addr_o,
  input  logic [7:0]        vram_data_i,
  input  logic [XW-1:0]     rd_addr_i,
  output logic [BPP+1:0]    rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  localparam int CW = $clog2(NUM_COLS);
  localparam logic [8:0]        VIS9       = 9'(VIS_ROWS);
  localparam logic [ADDR_W-1:0] TILE_BYTES = ADDR_W'(8 * BPP);
  localparam logic [ADDR_W-1:0] ROW_BYTES  = ADDR_W'(BPP);

  typedef enum logic [2:0] {
    S_IDLE, S_NAME_LO, S_NAME_HI, S_DECODE, S_PLANE, S_LAST, S_EMIT, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [2:0]             sub_q, sub_d;
  logic [7:0]             name_lo_q, name_lo_d;
  logic [4:0]             name_hi_q, name_hi_d;
  logic [BPP-1:0][7:0]    plane_q, plane_d;

  logic [7:0]             row_q, vs_q;
  logic [XW-1:0]          hs_q;
  logic                   hinhib_q, vinhib_q;
  logic [ADDR_W-1:0]      name_base_q, pat_base_q;

  logic                   fetch_bank_q;
  logic [1:0]             bank_valid_q;
  logic                   overrun_q;
  logic [BPP+1:0]         rd_data_q;
  logic [BPP+1:0]         lbuf [2*LINE_PIX];

  logic [8:0]             vsum_0, vsum_1;
  logic [7:0]             s_row;
  logic [2:0]             tile_row;
  logic [ADDR_W-1:0]      name_addr, pat_addr;
  logic [XW-1:0]          h_eff, wr_x;
  logic [BPP-1:0]         pix_col;
  logic [2:0]             pix_bit;
  logic                   lbuf_we;

  // Scrolled row: row+vScroll can reach 510, so up to two wrap subtractions.
  always_comb begin
    vsum_0 = {1'b0, row_q} + {1'b0, vs_q};
    vsum_1 = (vsum_0 >= VIS9) ? vsum_0 - VIS9 : vsum_0;
    s_row  = (vsum_1 >= VIS9) ? 8'(vsum_1 - VIS9) : vsum_1[7:0];
    if (vinhib_q && (int'(col_q) >= VLOCK_COL)) s_row = row_q;
  end

  always_comb begin
    tile_row  = name_hi_q[2] ? 3'd7 - s_row[2:0] : s_row[2:0];
    // NUM_COLS is a power of two, so NUM_COLS*srow_tile + col is a concatenation.
    name_addr = name_base_q + ADDR_W'({s_row[7:3], col_q, 1'b0});
    pat_addr  = pat_base_q + ADDR_W'({name_hi_q[0], name_lo_q}) * TILE_BYTES
                + ADDR_W'(tile_row) * ROW_BYTES;
    h_eff     = (hinhib_q && (int'(row_q) < HINHIB_ROWS)) ? '0 : hs_q;
    wr_x      = XW'({col_q, sub_q}) + h_eff;
    pix_bit   = name_hi_q[1] ? sub_q : 3'd7 - sub_q;
    pix_col   = '0;
    for (int b = 0; b < BPP; b++) pix_col[b] = plane_q[b][pix_bit];
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    sub_d       = sub_q;
    name_lo_d   = name_lo_q;
    name_hi_d   = name_hi_q;
    plane_d     = plane_q;
    vram_addr_o = name_base_i;
    lbuf_we     = 1'b0;
    unique case (state_q)
      S_IDLE: vram_addr_o = name_base_i;
      S_NAME_LO: begin
        vram_addr_o = name_addr;
        state_d     = S_NAME_HI;
      end
      S_NAME_HI: begin
        vram_addr_o = name_addr + ADDR_W'(1);
        name_lo_d   = vram_data_i;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        vram_addr_o = name_addr + ADDR_W'(1);
        name_hi_d   = vram_data_i[4:0];
        sub_d       = '0;
        state_d     = S_PLANE;
      end
      S_PLANE: begin
        vram_addr_o = pat_addr + ADDR_W'(sub_q);
        for (int k = 1; k < BPP; k++) if (sub_q == 3'(k)) plane_d[k-1] = vram_data_i;
        if (sub_q == 3'(BPP - 1)) state_d = S_LAST;
        else sub_d = sub_q + 3'd1;
      end
      S_LAST: begin
        vram_addr_o      = pat_addr + ADDR_W'(BPP - 1);
        plane_d[BPP-1]   = vram_data_i;
        sub_d            = '0;
        state_d          = S_EMIT;
      end
      S_EMIT: begin
        vram_addr_o = pat_addr + ADDR_W'(BPP - 1);
        lbuf_we     = 1'b1;
        if (sub_q == 3'd7) begin
          sub_d = '0;
          if (col_q == CW'(NUM_COLS - 1)) state_d = S_DONE;
          else begin
            col_d   = col_q + CW'(1);
            state_d = S_NAME_LO;
          end
        end else sub_d = sub_q + 3'd1;
      end
      S_DONE: begin
        vram_addr_o = pat_addr + ADDR_W'(BPP - 1);
        state_d     = S_IDLE;
      end
    endcase
    // A line start always (re)starts the walk, aborting any fetch in flight.
    if (line_start_i) begin
      state_d = S_NAME_LO;
      col_d   = '0;
      sub_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      sub_q        <= '0;
      name_lo_q    <= '0;
      name_hi_q    <= '0;
      plane_q      <= '0;
      row_q        <= '0;
      vs_q         <= '0;
      hs_q         <= '0;
      hinhib_q     <= 1'b0;
      vinhib_q     <= 1'b0;
      name_base_q  <= '0;
      pat_base_q   <= '0;
      fetch_bank_q <= 1'b0;
      bank_valid_q <= '0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      sub_q     <= sub_d;
      name_lo_q <= name_lo_d;
      name_hi_q <= name_hi_d;
      plane_q   <= plane_d;
      overrun_q <= line_start_i && (state_q != S_IDLE) && (state_q != S_DONE);
      // Completed bank is marked before a same-cycle swap clears the other one.
      if (state_q == S_DONE) bank_valid_q[fetch_bank_q] <= 1'b1;
      if (line_start_i) begin
        bank_valid_q[~fetch_bank_q] <= 1'b0;
        fetch_bank_q <= ~fetch_bank_q;
        row_q        <= row_i;
        vs_q         <= v_scroll_i;
        hs_q         <= h_scroll_i;
        hinhib_q     <= h_scroll_inhib_i;
        vinhib_q     <= v_scroll_inhib_i;
        name_base_q  <= name_base_i;
        pat_base_q   <= pattern_base_i;
      end
      rd_data_q <= bank_valid_q[~fetch_bank_q] ? lbuf[{~fetch_bank_q, rd_addr_i}] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (lbuf_we) lbuf[{fetch_bank_q, wr_x}] <= {name_hi_q[4], name_hi_q[3], pix_col};
  end

  assign rd_data_o = rd_data_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_bg_line_fetcher.sv
// Testbench for bg_line_fetcher at default parameters. Line-buffer reads are checked by
// a scoreboard: the stimulus pushes {x, expected} and a monitor pops and compares when
// the registered read data appears. Timing/status checks are made inline.
module tb_bg_line_fetcher;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        line_start_i;
  logic [7:0]  row_i, h_scroll_i, v_scroll_i;
  logic        h_scroll_inhib_i, v_scroll_inhib_i;
  logic [13:0] name_base_i, pattern_base_i, vram_addr_o;
  logic [7:0]  vram_data_i;
  logic [7:0]  rd_addr_i;
  logic [5:0]  rd_data_o;
  logic        busy_o, done_o, overrun_o;

  logic [7:0]  vram [0:16383];
  logic [13:0] exp_q [$];
  logic        rd_req = 1'b0;
  logic        rd_req_q = 1'b0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          total = 0;
  int          bad = 0;

  bg_line_fetcher dut (
    .clk_i(clk), .rst_i(rst_i), .line_start_i(line_start_i),
    .row_i(row_i), .h_scroll_i(h_scroll_i), .v_scroll_i(v_scroll_i),
    .h_scroll_inhib_i(h_scroll_inhib_i), .v_scroll_inhib_i(v_scroll_inhib_i),
    .name_base_i(name_base_i), .pattern_base_i(pattern_base_i),
    .vram_addr_o(vram_addr_o), .vram_data_i(vram_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    vram_data_i <= vram[vram_addr_o];
    rd_req_q    <= rd_req;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rd_req_q) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdData: output with empty queue got 0x%0h", rd_data_o);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        chk($sformatf("rdData x=%0d", e[13:6]), int'(rd_data_o), int'(e[5:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic set_name(input int base, input int r, input int c,
                          input logic [7:0] lo, input logic [7:0] hi);
    int a;
    a = base + 2 * (32 * r + c);
    vram[a]     = lo;
    vram[a + 1] = hi;
  endtask

  task automatic set_pat(input int tile, input int tr, input logic [7:0] p0,
                         input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3);
    int a;
    a = 32 * tile + 4 * tr;
    vram[a] = p0; vram[a + 1] = p1; vram[a + 2] = p2; vram[a + 3] = p3;
  endtask

  task automatic start_line(input bit now, input logic [7:0] r, input logic [7:0] hsc,
                            input logic [7:0] vsc, input logic hinh, input logic vinh,
                            input logic [13:0] nb);
    if (!now) @(negedge clk);
    row_i = r; h_scroll_i = hsc; v_scroll_i = vsc;
    h_scroll_inhib_i = hinh; v_scroll_inhib_i = vinh; name_base_i = nb;
    line_start_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    line_start_i = 1'b0;
  endtask

  task automatic rd(input int x, input logic [5:0] e);
    @(negedge clk);
    rd_addr_i = 8'(x);
    rd_req    = 1'b1;
    exp_q.push_back({8'(x), e});
  endtask

  task automatic rd_end();
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done latency"}, cyc - start_cyc, 513);
    chk({nm, " busy at done"}, int'(busy_o), 1);
  endtask

  task automatic after_done(input string nm);
    @(negedge clk);
    chk({nm, " done pulse width"}, int'(done_o), 0);
    chk({nm, " idle busy"}, int'(busy_o), 0);
  endtask

  initial begin
    rst_i = 1'b1; line_start_i = 1'b0; row_i = '0; h_scroll_i = '0; v_scroll_i = '0;
    h_scroll_inhib_i = 1'b0; v_scroll_inhib_i = 1'b0;
    name_base_i = 14'h1000; pattern_base_i = 14'h0000; rd_addr_i = '0;

    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 32; c++) begin
        set_name('h1000, r, c, 8'h05, 8'h18);
        set_name('h2000, r, c, 8'h05, 8'h00);
        set_name('h3000, r, c, 8'h05, 8'h00);
        set_name('h3800, r, c, 8'h05, 8'h00);
      end
    set_name('h2000, 1, 0, 8'h01, 8'h10);
    set_name('h2000, 1, 31, 8'h02, 8'h08);
    for (int c = 0; c < 32; c++) begin
      set_name('h3000, 3, c, 8'h03, 8'h00);
      set_name('h3000, 27, c, 8'h04, 8'h00);
    end
    set_name('h3800, 0, 0, 8'h07, 8'h06);
    set_name('h3800, 0, 1, 8'h05, 8'h01);
    for (int tr = 0; tr < 8; tr++) begin
      set_pat(5, tr, 8'hFF, 8'hFF, 8'h00, 8'h00);
      set_pat(1, tr, 8'h80, 8'h00, 8'h00, 8'h80);
      set_pat(2, tr, 8'h00, 8'h04, 8'h00, 8'h00);
      set_pat(7, tr, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    end
    set_pat(3, 6, 8'hFF, 8'h00, 8'h00, 8'h00);
    set_pat(4, 7, 8'h00, 8'hFF, 8'h00, 8'h00);
    set_pat(7, 7, 8'h80, 8'h00, 8'h00, 8'h00);
    set_pat(261, 0, 8'h00, 8'h00, 8'hFF, 8'h00);

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy_o), 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset rdData", int'(rd_data_o), 0);
    chk("reset busy after release", int'(busy_o), 0);
    chk("reset done", int'(done_o), 0);
    chk("reset overrun", int'(overrun_o), 0);
    chk("reset vramAddr", int'(vram_addr_o), 'h1000);

    // L1: uniform tiles, row 9; check the address walk of column 0
    start_line(0, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 14'h1000);
    chk("L1 busy", int'(busy_o), 1);
    chk("L1 addr NAME_LO", int'(vram_addr_o), 'h1040);
    @(negedge clk); chk("L1 addr NAME_HI", int'(vram_addr_o), 'h1041);
    @(negedge clk); chk("L1 addr DECODE", int'(vram_addr_o), 'h1041);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("L1 addr PLANE%0d", k), int'(vram_addr_o), 'h00A4 + k);
    end
    wait_done("L1");
    after_done("L1");
    rd(0, 6'h00); rd(100, 6'h00); rd_end();

    // L2: hScroll=3 on name base 0x2000; read L1 bank
    start_line(0, 8'd9, 8'd3, 8'd0, 1'b0, 1'b0, 14'h2000);
    for (int x = 0; x < 256; x++) rd(x, 6'h33);
    rd_end();
    wait_done("L2");
    after_done("L2");

    // L3: hScrollInhib with row 8; read L2 bank
    start_line(0, 8'd8, 8'd3, 8'd0, 1'b1, 1'b0, 14'h2000);
    rd(0, 6'h12); rd(2, 6'h10); rd(3, 6'h29); rd(4, 6'h20);
    rd(11, 6'h03); rd(250, 6'h03); rd(254, 6'h10); rd(255, 6'h10);
    rd_end();
    wait_done("L3");
    after_done("L3");

    // L4: vScroll=255, row 223 -> scrolled row 30; read L3 bank
    start_line(0, 8'd223, 8'd0, 8'd255, 1'b0, 1'b0, 14'h3000);
    rd(0, 6'h29); rd(1, 6'h20); rd(7, 6'h20); rd(8, 6'h03);
    rd(248, 6'h10); rd(253, 6'h12); rd(255, 6'h10);
    rd_end();
    wait_done("L4");
    after_done("L4");

    // L5: same with vScrollInhib; read L4 bank
    start_line(0, 8'd223, 8'd0, 8'd255, 1'b0, 1'b1, 14'h3000);
    rd(0, 6'h01); rd(191, 6'h01); rd(192, 6'h01); rd(255, 6'h01);
    rd_end();
    wait_done("L5");
    after_done("L5");

    // L6: h+v flipped tile and a tile number above 255; read L5 bank
    start_line(0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 14'h3800);
    rd(0, 6'h01); rd(191, 6'h01); rd(192, 6'h02); rd(255, 6'h02);
    rd_end();
    wait_done("L6");
    after_done("L6");

    // L7: read L6 bank, then abort at cycle 200 with L8
    start_line(0, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 14'h1000);
    rd(0, 6'h00); rd(3, 6'h00); rd(6, 6'h00); rd(7, 6'h01);
    rd(8, 6'h04); rd(15, 6'h04); rd(16, 6'h03);
    rd_end();
    while (cyc - start_cyc < 199) @(negedge clk);
    start_line(0, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 14'h1000);
    chk("L8 overrun pulse", int'(overrun_o), 1);
    chk("L8 busy", int'(busy_o), 1);
    chk("L8 restart addr", int'(vram_addr_o), 'h1040);
    @(negedge clk);
    chk("L8 overrun width", int'(overrun_o), 0);
    rd(0, 6'h00); rd(128, 6'h00);
    rd_end();
    wait_done("L8");

    // L9: line start in the DONE cycle is not an overrun
    start_line(1, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 14'h1000);
    chk("L9 no overrun at done", int'(overrun_o), 0);
    chk("L9 busy", int'(busy_o), 1);
    rd(0, 6'h33); rd(255, 6'h33);
    rd_end();
    wait_done("L9");
    after_done("L9");

    repeat (2) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
